sdrc_burst_splitter: RTL and testbench

Sequences application read/write length requests into page-bounded sub-bursts for the SDRAM request generator. It sits between the application request port and the bank request path. It drives the column-remaining and length-remaining subtraction datapath once per chunk. Each issued sub-burst stays inside one SDRAM page (2^CW words) and never exceeds the words remaining in the original request.

---
 rtl/sdrc_burst_splitter_if.sv | 27 ++
 rtl/sdrc_burst_splitter.sv | 122 ++++++++++++
 tb/tb_sdrc_burst_splitter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/sdrc_burst_splitter_if.sv
// Request/sub-burst bundle between the application port, the burst splitter
// and the bank request path.
interface sdrc_burst_splitter_if #(
  parameter int AW = 26,
  parameter int LW = 7
);
  logic          req;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          req_ack;
  logic          busy;
  logic          sub_req;
  logic [AW-1:0] sub_addr;
  logic [LW-1:0] sub_len;
  logic          sub_last;
  logic          sub_ack;

  modport master (
    output req, req_addr, req_len, sub_ack,
    input  req_ack, busy, sub_req, sub_addr, sub_len, sub_last
  );

  modport slave (
    input  req, req_addr, req_len, sub_ack,
    output req_ack, busy, sub_req, sub_addr, sub_len, sub_last
  );
endinterface

// File: rtl/sdrc_burst_splitter.sv
// Splits an application length request into sub-bursts that never cross an
// SDRAM page (2^CW words) and never exceed the remaining request length.
module sdrc_burst_splitter #(
  parameter int AW = 26,
  parameter int LW = 7,
  parameter int CW = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  sdrc_burst_splitter_if.slave   bus
);

  localparam int CMPW = (LW > CW + 1) ? LW : CW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t        state_r;
  logic [AW-1:0] rem_addr_r;
  logic [LW-1:0] rem_len_r;
  logic          req_ack_r;
  logic          busy_r;
  logic          sub_req_r;
  logic [AW-1:0] sub_addr_r;
  logic [LW-1:0] sub_len_r;
  logic          sub_last_r;

  logic [CW:0]     page_rem_s;
  logic [CMPW-1:0] page_rem_x_s;
  logic [CMPW-1:0] rem_len_x_s;
  logic [CMPW-1:0] chunk_x_s;
  logic [LW-1:0]   chunk_len_s;
  logic            chunk_last_s;

  // Chunk size: words left in the current page, clipped to the words left in the request.
  always_comb begin
    page_rem_s   = {1'b1, {CW{1'b0}}} - {1'b0, rem_addr_r[CW-1:0]};
    page_rem_x_s = CMPW'(page_rem_s);
    rem_len_x_s  = CMPW'(rem_len_r);
    if (rem_len_x_s <= page_rem_x_s) begin
      chunk_x_s = rem_len_x_s;
    end else begin
      chunk_x_s = page_rem_x_s;
    end
    chunk_len_s  = LW'(chunk_x_s);
    chunk_last_s = (chunk_x_s == rem_len_x_s);
  end

  // Request sequencer: capture, compute each chunk, then hold it until accepted.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      rem_addr_r <= {AW{1'b0}};
      rem_len_r  <= {LW{1'b0}};
      req_ack_r  <= 1'b0;
      busy_r     <= 1'b0;
      sub_req_r  <= 1'b0;
      sub_addr_r <= {AW{1'b0}};
      sub_len_r  <= {LW{1'b0}};
      sub_last_r <= 1'b0;
    end else begin
      req_ack_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.req) begin
            req_ack_r  <= 1'b1;
            rem_addr_r <= bus.req_addr;
            rem_len_r  <= bus.req_len;
            // A zero-length request is acknowledged but never issues anything.
            if (bus.req_len != {LW{1'b0}}) begin
              state_r <= CALC;
              busy_r  <= 1'b1;
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          sub_addr_r <= rem_addr_r;
          sub_len_r  <= chunk_len_s;
          sub_last_r <= chunk_last_s;
          sub_req_r  <= 1'b1;
          state_r    <= ISSUE;
        end
        ISSUE: begin
          if (bus.sub_ack) begin
            sub_req_r  <= 1'b0;
            rem_len_r  <= rem_len_r - sub_len_r;
            rem_addr_r <= rem_addr_r + AW'(sub_len_r);
            if (sub_last_r) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= CALC;
            end
          end else begin
            state_r <= ISSUE;
          end
        end
        default: begin
          state_r   <= IDLE;
          busy_r    <= 1'b0;
          sub_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ack  = req_ack_r;
  assign bus.busy     = busy_r;
  assign bus.sub_req  = sub_req_r;
  assign bus.sub_addr = sub_addr_r;
  assign bus.sub_len  = sub_len_r;
  assign bus.sub_last = sub_last_r;

endmodule

// File: tb/tb_sdrc_burst_splitter.sv
// Scoreboard bench for sdrc_burst_splitter: a reference page-split model queues
// the expected sub-bursts, which are compared as the DUT presents them.
module tb_sdrc_burst_splitter;

  localparam int AW = 26;
  localparam int LW = 7;
  localparam int CW = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic          last;
  } exp_t;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;
  exp_t exp_q[$];

  sdrc_burst_splitter_if #(.AW(AW), .LW(LW)) bus ();

  sdrc_burst_splitter #(.AW(AW), .LW(LW), .CW(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: walk the request page by page.
  task automatic push_expected(input logic [AW-1:0] addr, input logic [LW-1:0] len);
    logic [AW-1:0] a;
    int            l;
    int            pr;
    int            c;
    exp_t          e;
    a = addr;
    l = int'(len);
    while (l > 0) begin
      pr = (1 << CW) - int'(a[CW-1:0]);
      c  = (l < pr) ? l : pr;
      e.addr = a;
      e.len  = LW'(c);
      e.last = (c == l);
      exp_q.push_back(e);
      a = a + AW'(c);
      l = l - c;
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 (CALC).
  task automatic send_req(input logic [AW-1:0] addr, input logic [LW-1:0] len);
    bus.req      = 1'b1;
    bus.req_addr = addr;
    bus.req_len  = len;
    push_expected(addr, len);
    @(negedge clk);
    bus.req = 1'b0;
    checks++;
    if (bus.req_ack !== 1'b1) begin
      errors++;
      $display("FAIL req_ack_cycle1: got %b expected 1 (addr=%h len=%0d)", bus.req_ack, addr, len);
    end
    checks++;
    if (bus.busy !== (len != 7'd0)) begin
      errors++;
      $display("FAIL busy_cycle1: got %b expected %b (len=%0d)", bus.busy, (len != 7'd0), len);
    end
  endtask

  // Accept every queued sub-burst, holding sub_ack low for 'stall' cycles each.
  task automatic serve(input int stall);
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      checks++;
      if (bus.sub_req !== 1'b1 || bus.busy !== 1'b1 || bus.req_ack !== 1'b0) begin
        errors++;
        $display("FAIL sub_req_timing: got sub_req=%b busy=%b req_ack=%b expected 1 1 0",
                 bus.sub_req, bus.busy, bus.req_ack);
      end
      checks++;
      if (bus.sub_addr !== e.addr || bus.sub_len !== e.len || bus.sub_last !== e.last) begin
        errors++;
        $display("FAIL sub_fields: got {%h,%0d,%b} expected {%h,%0d,%b}",
                 bus.sub_addr, bus.sub_len, bus.sub_last, e.addr, e.len, e.last);
      end
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        checks++;
        if (bus.sub_req !== 1'b1 || bus.sub_addr !== e.addr || bus.sub_len !== e.len ||
            bus.sub_last !== e.last) begin
          errors++;
          $display("FAIL stall_stable: got {%b,%h,%0d,%b} expected {1,%h,%0d,%b}",
                   bus.sub_req, bus.sub_addr, bus.sub_len, bus.sub_last, e.addr, e.len, e.last);
        end
      end
      bus.sub_ack = 1'b1;
      @(negedge clk);
      bus.sub_ack = 1'b0;
      checks++;
      if (bus.sub_req !== 1'b0 || bus.busy !== !e.last) begin
        errors++;
        $display("FAIL after_ack: got sub_req=%b busy=%b expected 0 %b", bus.sub_req, bus.busy, !e.last);
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.req_ack !== 1'b0 || bus.busy !== 1'b0 || bus.sub_req !== 1'b0 || bus.sub_last !== 1'b0 ||
        bus.sub_addr !== 26'd0 || bus.sub_len !== 7'd0) begin
      errors++;
      $display("FAIL reset_state: got ack=%b busy=%b sub_req=%b last=%b addr=%h len=%0d expected all 0",
               bus.req_ack, bus.busy, bus.sub_req, bus.sub_last, bus.sub_addr, bus.sub_len);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    send_req(26'h0000010, 7'd16);
    serve(0);
  endtask

  task automatic test_page_cross;
    send_req(26'h00000F8, 7'd20);
    serve(0);
    send_req(26'h00000C0, 7'd127);
    serve(0);
  endtask

  task automatic test_wrap;
    send_req(26'h3FFFFFC, 7'd10);
    serve(0);
  endtask

  task automatic test_stall;
    send_req(26'h3FFFFFC, 7'd10);
    serve(5);
  endtask

  task automatic test_zero_len;
    send_req(26'h0000123, 7'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.sub_req !== 1'b0 || bus.busy !== 1'b0 || bus.req_ack !== 1'b0) begin
        errors++;
        $display("FAIL zero_len_idle: got sub_req=%b busy=%b req_ack=%b expected 0 0 0",
                 bus.sub_req, bus.busy, bus.req_ack);
      end
    end
    send_req(26'h0000020, 7'd4);
    serve(0);
  endtask

  task automatic test_mid_reset;
    send_req(26'h00000F8, 7'd20);
    @(negedge clk);
    checks++;
    if (bus.sub_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_issue: got sub_req=%b expected 1", bus.sub_req);
    end
    exp_q.delete();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if (bus.sub_req !== 1'b0 || bus.busy !== 1'b0 || bus.sub_last !== 1'b0 ||
        bus.sub_addr !== 26'd0 || bus.sub_len !== 7'd0) begin
      errors++;
      $display("FAIL mid_reset_clear: got sub_req=%b busy=%b last=%b addr=%h len=%0d expected all 0",
               bus.sub_req, bus.busy, bus.sub_last, bus.sub_addr, bus.sub_len);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.req_ack !== 1'b0 || bus.sub_req !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_quiet: got req_ack=%b sub_req=%b expected 0 0", bus.req_ack, bus.sub_req);
      end
    end
    send_req(26'h0000040, 7'd5);
    serve(0);
  endtask

  task automatic test_back_to_back;
    send_req(26'h00001F0, 7'd100);
    serve(0);
    send_req(26'h0000300, 7'd50);
    serve(1);
  endtask

  task automatic test_random;
    logic [AW-1:0] a;
    logic [LW-1:0] l;
    for (int i = 0; i < 12; i++) begin
      a = AW'($urandom);
      l = LW'($urandom_range(0, 127));
      send_req(a, l);
      serve(i % 3);
    end
  endtask

  initial begin
    clk          = 1'b0;
    reset_n      = 1'b0;
    errors       = 0;
    checks       = 0;
    bus.req      = 1'b0;
    bus.req_addr = 26'd0;
    bus.req_len  = 7'd0;
    bus.sub_ack  = 1'b0;
    test_reset();
    test_single();
    test_page_cross();
    test_wrap();
    test_stall();
    test_zero_len();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
